// File: rtl/edge_detector_controller.sv
// edge_detector_controller: sequences one frame through load, 3x3 convolve and stream-out,
// decoding datapath strobes from the current state and handshake inputs.
module edge_detector_controller #(
    parameter int FRAME_CNT_W   = 16,
    parameter int CALC_CYCLES_W = 20
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     pixValid_i,
    output logic                     pixReady_o,
    output logic                     outValid_o,
    input  logic                     outReady_i,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic                     inputRecieved_i,
    input  logic                     kernelResReady_i,
    input  logic                     imageProcessed_i,
    output logic                     cntrInputClear_o,
    output logic                     cntrKernelClear_o,
    output logic                     cntrMemGclear_o,
    output logic                     memGclear_o,
    output logic                     memImgWr_o,
    output logic                     cntrInputInc_o,
    output logic                     saveImgOrCalculate_o,
    output logic                     cntrKernelInc_o,
    output logic                     memGwr_o,
    output logic                     cntrMemGinc_o,
    output logic [FRAME_CNT_W-1:0]   frameCount_o,
    output logic [CALC_CYCLES_W-1:0] calcCycles_o
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CALC, OUTPUT} state_t;
    state_t state;
    logic in_clear, in_load, in_calc, in_out;
    assign in_clear = state == CLEAR;
    assign in_load  = state == LOAD;
    assign in_calc  = state == CALC;
    assign in_out   = state == OUTPUT;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            frameCount_o <= '0;
            calcCycles_o <= '0;
        end else begin
            case (state)
                IDLE:   if (start_i) state <= CLEAR;
                CLEAR: begin
                    calcCycles_o <= '0;
                    state        <= LOAD;
                end
                LOAD:   if (pixValid_i && inputRecieved_i) state <= CALC;
                CALC: begin
                    if (~&calcCycles_o) calcCycles_o <= calcCycles_o + CALC_CYCLES_W'(1);
                    if (kernelResReady_i && imageProcessed_i) state <= OUTPUT;
                end
                OUTPUT: if (outReady_i && imageProcessed_i) begin
                    frameCount_o <= frameCount_o + FRAME_CNT_W'(1);
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy_o               = in_clear || in_load || in_calc || in_out;
    assign pixReady_o           = in_load;
    assign outValid_o           = in_out;
    assign done_o               = in_out && outReady_i && imageProcessed_i;
    assign cntrInputClear_o     = in_clear;
    assign cntrKernelClear_o    = in_clear;
    assign cntrMemGclear_o      = in_clear;
    assign memGclear_o          = in_clear;
    assign memImgWr_o           = in_load && pixValid_i;
    assign cntrInputInc_o       = in_load && pixValid_i;
    assign saveImgOrCalculate_o = in_calc;
    assign cntrKernelInc_o      = in_calc;
    assign memGwr_o             = in_calc;
    // G counter steps once per finished kernel in CALC, once per accepted pixel in OUTPUT
    assign cntrMemGinc_o        = (in_calc && kernelResReady_i) || (in_out && outReady_i);
endmodule

// File: tb/tb_edge_detector_controller.sv
// tb_edge_detector_controller: drives a 5x5-frame datapath stand-in and checks the controller
// against a count-based phase model every cycle, plus hand-computed frame statistics.
module tb_edge_detector_controller;
    localparam int NPIX = 25, NTAP = 81, NOUT = 9;
    logic clk_i = 0, rst_i = 1, start_i = 0, pixValid_i = 0, outReady_i = 1;
    logic pixReady_o, outValid_o, busy_o, done_o;
    logic inputRecieved_i, kernelResReady_i, imageProcessed_i;
    logic cntrInputClear_o, cntrKernelClear_o, cntrMemGclear_o, memGclear_o;
    logic memImgWr_o, cntrInputInc_o, saveImgOrCalculate_o, cntrKernelInc_o, memGwr_o, cntrMemGinc_o;
    logic [15:0] frameCount_o;
    logic [19:0] calcCycles_o;
    int passed = 0, total = 0;

    edge_detector_controller dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pixValid_i(pixValid_i),
        .pixReady_o(pixReady_o), .outValid_o(outValid_o), .outReady_i(outReady_i),
        .busy_o(busy_o), .done_o(done_o), .inputRecieved_i(inputRecieved_i),
        .kernelResReady_i(kernelResReady_i), .imageProcessed_i(imageProcessed_i),
        .cntrInputClear_o(cntrInputClear_o), .cntrKernelClear_o(cntrKernelClear_o),
        .cntrMemGclear_o(cntrMemGclear_o), .memGclear_o(memGclear_o),
        .memImgWr_o(memImgWr_o), .cntrInputInc_o(cntrInputInc_o),
        .saveImgOrCalculate_o(saveImgOrCalculate_o), .cntrKernelInc_o(cntrKernelInc_o),
        .memGwr_o(memGwr_o), .cntrMemGinc_o(cntrMemGinc_o),
        .frameCount_o(frameCount_o), .calcCycles_o(calcCycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Datapath stand-in: 25-pixel input counter, 9-tap kernel counter, 9-entry G counter
    int in_cnt = 0, k_cnt = 0, g_cnt = 0;
    assign inputRecieved_i  = in_cnt == NPIX - 1;
    assign kernelResReady_i = k_cnt == 8;
    assign imageProcessed_i = g_cnt == NOUT - 1;
    always @(posedge clk_i) begin
        in_cnt <= cntrInputClear_o ? 0 : cntrInputInc_o ? (in_cnt + 1) % NPIX : in_cnt;
        k_cnt  <= cntrKernelClear_o ? 0 : cntrKernelInc_o ? (k_cnt + 1) % 9 : k_cnt;
        g_cnt  <= cntrMemGclear_o ? 0 : cntrMemGinc_o ? (g_cnt + 1) % NOUT : g_cnt;
    end

    // Behavioural model: phase plus remaining-work counts
    localparam int P_IDLE = 0, P_CLEAR = 1, P_LOAD = 2, P_CALC = 3, P_OUT = 4;
    int ph = P_IDLE, pix_left = 0, taps = 0, out_left = 0, m_frames = 0, m_calc = 0;
    logic chk_en = 0;
    logic [13:0] act_v, exp_v;
    assign act_v = {pixReady_o, outValid_o, busy_o, done_o, cntrInputClear_o, cntrKernelClear_o,
                    cntrMemGclear_o, memGclear_o, memImgWr_o, cntrInputInc_o,
                    saveImgOrCalculate_o, cntrKernelInc_o, memGwr_o, cntrMemGinc_o};
    always @(negedge clk_i) begin
        exp_v = '0;
        if (ph == P_CLEAR) exp_v = 14'b00101111000000;
        if (ph == P_LOAD)  exp_v = {1'b1, 1'b0, 1'b1, 5'b0, pixValid_i, pixValid_i, 4'b0};
        if (ph == P_CALC)  exp_v = {2'b00, 1'b1, 7'b0, 3'b111, taps % 9 == 8};
        if (ph == P_OUT)   exp_v = {2'b01, 1'b1, outReady_i && out_left == 1, 9'b0, outReady_i};
        if (chk_en) begin
            chk("controls", act_v, exp_v);
            chk("frame_count", frameCount_o, m_frames);
            chk("calc_cycles", calcCycles_o, m_calc);
        end
        if (rst_i) begin
            ph = P_IDLE; m_frames = 0; m_calc = 0;
        end else if (ph == P_IDLE) begin
            if (start_i) ph = P_CLEAR;
        end else if (ph == P_CLEAR) begin
            ph = P_LOAD; pix_left = NPIX; m_calc = 0;
        end else if (ph == P_LOAD) begin
            if (pixValid_i) pix_left--;
            if (pixValid_i && pix_left == 0) begin ph = P_CALC; taps = 0; end
        end else if (ph == P_CALC) begin
            m_calc = m_calc == 20'hFFFFF ? m_calc : m_calc + 1;
            taps++;
            if (taps == NTAP) begin ph = P_OUT; out_left = NOUT; end
        end else if (ph == P_OUT) begin
            if (outReady_i) out_left--;
            if (outReady_i && out_left == 0) begin ph = P_IDLE; m_frames++; end
        end
    end

    // Frame statistics
    logic clr_stats = 1;
    int writes, load_cyc, calc_cyc, g_calc, out_cyc, hs, dones;
    always @(negedge clk_i) begin
        if (clr_stats) begin
            writes <= 0; load_cyc <= 0; calc_cyc <= 0; g_calc <= 0; out_cyc <= 0; hs <= 0; dones <= 0;
        end else begin
            writes   <= writes + int'(memImgWr_o);
            load_cyc <= load_cyc + int'(pixReady_o);
            calc_cyc <= calc_cyc + int'(saveImgOrCalculate_o);
            g_calc   <= g_calc + int'(saveImgOrCalculate_o && cntrMemGinc_o);
            out_cyc  <= out_cyc + int'(outValid_o);
            hs       <= hs + int'(outValid_o && outReady_i);
            dones    <= dones + int'(done_o);
        end
    end

    task automatic do_reset();
        rst_i = 1; clr_stats = 1; start_i = 0; outReady_i = 1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0; clr_stats = 0; chk_en = 1;
    endtask

    task automatic run_frame(input bit pv_tog, input int slo, input int shi, input int rst_at, input int sp_at);
        bit seen = 0;
        for (int k = 0; k < 400; k++) begin
            start_i    = (k == 0) || (k == sp_at);
            pixValid_i = pv_tog ? (k % 2 == 0) : 1'b1;
            outReady_i = !(k >= slo && k <= shi);
            rst_i      = k == rst_at;
            @(negedge clk_i);
            if (done_o) seen = 1;
            @(posedge clk_i);
            #1;
            if (seen || k == rst_at) break;
        end
        start_i = 0; rst_i = 0; outReady_i = 1;
        if (rst_at < 0) chk("frame_done_in_budget", seen, 1);
    endtask

    initial begin
        do_reset();
        chk("reset_busy", busy_o, 0);
        chk("reset_controls", act_v, 0);
        chk("reset_frames", frameCount_o, 0);
        // Plain frame
        run_frame(0, -1, -1, -1, -1);
        chk("f1_writes", writes, 25);
        chk("f1_load_cycles", load_cyc, 25);
        chk("f1_calc_cycles", calc_cyc, 81);
        chk("f1_g_inc_in_calc", g_calc, 9);
        chk("f1_out_cycles", out_cyc, 9);
        chk("f1_dones", dones, 1);
        chk("f1_frame_count", frameCount_o, 1);
        chk("f1_calc_counter", calcCycles_o, 81);
        // Toggling pixel valid
        do_reset();
        run_frame(1, -1, -1, -1, -1);
        chk("tog_writes", writes, 25);
        chk("tog_load_cycles", load_cyc, 49);
        chk("tog_frame_count", frameCount_o, 1);
        // Output stall of 3 cycles
        do_reset();
        run_frame(0, 110, 112, -1, -1);
        chk("stall_out_cycles", out_cyc, 12);
        chk("stall_handshakes", hs, 9);
        chk("stall_dones", dones, 1);
        // Reset in the 40th CALC cycle
        do_reset();
        run_frame(0, -1, -1, 66, -1);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_controls", act_v, 0);
        clr_stats = 1;
        @(posedge clk_i);
        #1 clr_stats = 0;
        run_frame(0, -1, -1, -1, -1);
        chk("midrst_frame_count", frameCount_o, 1);
        chk("midrst_writes", writes, 25);
        chk("midrst_calc_counter", calcCycles_o, 81);
        // Start pulsed during LOAD is ignored
        do_reset();
        run_frame(0, -1, -1, -1, 10);
        chk("spurious_start_load", load_cyc, 25);
        chk("spurious_start_dones", dones, 1);
        repeat (3) @(posedge clk_i);
        #1 chk("spurious_start_idle", busy_o, 0);
        // Three back-to-back frames with start held high
        do_reset();
        begin
            int n = 0, gaps = 0;
            start_i = 1; pixValid_i = 1;
            for (int k = 0; k < 1000 && n < 3; k++) begin
                @(negedge clk_i);
                if (n >= 1 && !busy_o) gaps++;
                if (done_o) n++;
                @(posedge clk_i);
                #1;
            end
            start_i = 0;
            chk("b2b_done_count", n, 3);
            chk("b2b_idle_gaps", gaps, 2);
            chk("b2b_frame_count", frameCount_o, 3);
            chk("b2b_calc_counter", calcCycles_o, 81);
        end
        repeat (3) @(posedge clk_i);
        #1 chk("b2b_final_idle", busy_o, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
